// File: rtl/ulx3s_pll_phase_ctrl_pkg.sv
// rtl/ulx3s_pll_phase_ctrl_pkg.sv - shared FSM state and output-select encodings
package ulx3s_pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    SETTLE   = 3'd3,
    WAITLOCK = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ulx3s_pll_phase_ctrl_sync2.sv
// rtl/ulx3s_pll_phase_ctrl_sync2.sv - two-flop synchronizer for the PLL lock input
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ulx3s_pll_phase_ctrl.sv
// rtl/ulx3s_pll_phase_ctrl.sv - ECP5 PLL dynamic phase stepper with per-output offset tracking
module ulx3s_pll_phase_ctrl
  import ulx3s_pll_phase_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TO    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_count,
  input  logic       pll_locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       done,
  output logic       err,
  output logic       busy,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_ofs
);

  localparam int TMAX = max4(SETUP_CYC, PULSE_CYC, SETTLE_CYC, LOCK_TO);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SETUP_END  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_END  = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] LOCK_END   = TW'(LOCK_TO - 1);

  state_t        state;
  state_t        state_nx;
  logic          lock_s;
  logic [TW-1:0] timer;
  logic [7:0]    remaining;
  logic [1:0]    sel_q;
  logic          dir_q;
  logic          step_q;
  logic [7:0]    ofs [4];
  logic          accept;
  logic          pulse_end;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign req_ready    = (state == IDLE) && lock_s;
  assign accept       = req_valid && req_ready;
  assign pulse_end    = (state == PULSE) && (timer == PULSE_END);
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b1;
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign busy         = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = (req_count == 8'd0) ? DONE : SETUP;
      SETUP:    if (timer == SETUP_END) state_nx = PULSE;
      PULSE:    if (timer == PULSE_END) state_nx = SETTLE;
      SETTLE:   if (timer == SETTLE_END) state_nx = WAITLOCK;
      WAITLOCK: begin
        if (lock_s)                 state_nx = (remaining != 8'd0) ? SETUP : DONE;
        else if (timer == LOCK_END) state_nx = ERR;
      end
      DONE:     state_nx = IDLE;
      ERR:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // phasestep is registered from the next state so the PLL sees a glitch-free strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= 8'd0;
      sel_q     <= SEL_CLKOS;
      dir_q     <= 1'b0;
      step_q    <= 1'b1;
      for (int i = 0; i < 4; i++) ofs[i] <= 8'd0;
    end else begin
      state  <= state_nx;
      timer  <= (state_nx != state) ? '0 : timer + 1'b1;
      step_q <= (state_nx != PULSE);
      if (accept) begin
        sel_q     <= req_sel;
        dir_q     <= req_dir;
        remaining <= req_count;
      end
      if (pulse_end) begin
        ofs[sel_q] <= dir_q ? ofs[sel_q] + 8'd1 : ofs[sel_q] - 8'd1;
        remaining  <= remaining - 8'd1;
      end
    end
  end

  always_comb begin
    rd_ofs = ofs[0];
    case (rd_sel)
      SEL_CLKOS:  rd_ofs = ofs[0];
      SEL_CLKOS2: rd_ofs = ofs[1];
      SEL_CLKOS3: rd_ofs = ofs[2];
      SEL_CLKOP:  rd_ofs = ofs[3];
      default:    rd_ofs = ofs[0];
    endcase
  end

endmodule

// File: tb/tb_ulx3s_pll_phase_ctrl.sv
// tb/tb_ulx3s_pll_phase_ctrl.sv - self-checking bench for ulx3s_pll_phase_ctrl
`timescale 1ns/1ps
module tb_ulx3s_pll_phase_ctrl;

  localparam int SETUP_CYC  = 4;
  localparam int PULSE_CYC  = 4;
  localparam int SETTLE_CYC = 16;
  localparam int LOCK_TO    = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'b00;
  logic       req_dir = 1'b0;
  logic [7:0] req_count = 8'd0;
  logic       pll_locked = 1'b0;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       done;
  logic       err;
  logic       busy;
  logic [1:0] rd_sel = 2'b00;
  logic [7:0] rd_ofs;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_ofs [4];

  int   pulses = 0;
  int   bad_width = 0;
  int   run = 0;
  int   since_fall = 1000;
  int   sel_stable = 0;
  int   min_setup = 1000;
  int   min_space = 1000;
  logic last_ps = 1'b1;
  logic [2:0] last_sd = 3'b000;

  ulx3s_pll_phase_ctrl #(
    .SETUP_CYC  (SETUP_CYC),
    .PULSE_CYC  (PULSE_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .LOCK_TO    (LOCK_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_count    (req_count),
    .pll_locked   (pll_locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .rd_sel       (rd_sel),
    .rd_ofs       (rd_ofs)
  );

  always #5 clk = ~clk;

  // Pulse observer: widths, select setup time and pulse-to-pulse spacing.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      last_ps = 1'b1;
    end else begin
      if ({phasesel, phasedir} != last_sd) sel_stable = 0;
      else sel_stable++;
      last_sd = {phasesel, phasedir};
      since_fall++;
      if (phasestep == 1'b0) begin
        if (last_ps) begin
          if (sel_stable < min_setup) min_setup = sel_stable;
          if (since_fall < min_space) min_space = since_fall;
          since_fall = 0;
        end
        run++;
      end else if (!last_ps) begin
        pulses++;
        if (run != PULSE_CYC) bad_width++;
        run = 0;
      end
      last_ps = phasestep;
    end
  end

  task automatic issue(input logic [1:0] sel, input logic dir, input logic [7:0] cnt, output bit ok);
    int k;
    req_sel = sel;
    req_dir = dir;
    req_count = cnt;
    req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (req_ready === 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int nd, output int ne, output bit ok);
    int k;
    k = 0; nd = 0; ne = 0;
    while (k < 5000) begin
      if (done === 1'b1) nd++;
      if (err === 1'b1) ne++;
      if (busy === 1'b0) break;
      @(posedge clk); #1;
      k++;
    end
    ok = (k < 5000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    for (int i = 0; i < 4; i++) model_ofs[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({phasestep, phasesel, phasedir, done, err, busy, phaseloadreg} !== 8'b1_00_0_000_1) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {phasestep, phasesel, phasedir, done, err, busy, phaseloadreg}, 8'b10000001);
    end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (phasestep !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release step=%b ready=%b busy=%b want 1 0 0", phasestep, req_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (rd_ofs !== 8'd0) begin
        failures++;
        $display("FAIL reset_ofs[%0d] got=%h want=00", i, rd_ofs);
      end
    end
    pll_locked = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dir_steps();
    bit ok; int nd, ne, p0;
    p0 = pulses; min_setup = 1000; min_space = 1000;
    issue(2'b01, 1'b1, 8'd3, ok);
    wait_idle(nd, ne, ok);
    model_ofs[1] = model_ofs[1] + 8'd3;
    checks++;
    if (pulses - p0 != 3 || bad_width != 0) begin
      failures++;
      $display("FAIL adv3_pulses got=%0d badw=%0d want=3 badw=0", pulses - p0, bad_width);
    end
    checks++;
    if (min_setup < SETUP_CYC || min_space < 20) begin
      failures++;
      $display("FAIL adv3_timing setup=%0d space=%0d want setup>=%0d space>=20", min_setup, min_space, SETUP_CYC);
    end
    checks++;
    if (nd != 1 || ne != 0 || !ok) begin
      failures++;
      $display("FAIL adv3_done done=%0d err=%0d ok=%0d want 1 0 1", nd, ne, ok);
    end
    p0 = pulses;
    issue(2'b01, 1'b0, 8'd5, ok);
    wait_idle(nd, ne, ok);
    model_ofs[1] = model_ofs[1] - 8'd5;
    checks++;
    if (pulses - p0 != 5 || nd != 1 || bad_width != 0) begin
      failures++;
      $display("FAIL dly5_pulses got=%0d done=%0d want=5 1", pulses - p0, nd);
    end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (rd_ofs !== model_ofs[i]) begin
        failures++;
        $display("FAIL dly5_ofs[%0d] got=%h want=%h", i, rd_ofs, model_ofs[i]);
      end
    end
  endtask

  task automatic test_count_zero();
    bit ok; int p0;
    p0 = pulses;
    issue(2'b10, 1'b1, 8'd0, ok);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || !ok) begin
      failures++;
      $display("FAIL zero_done_pulse done=%b busy=%b want 1 1", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pulses != p0) begin
      failures++;
      $display("FAIL zero_return done=%b busy=%b pulses=%0d want 0 0 0", done, busy, pulses - p0);
    end
    rd_sel = 2'b10; #1;
    checks++;
    if (rd_ofs !== model_ofs[2]) begin
      failures++;
      $display("FAIL zero_ofs got=%h want=%h", rd_ofs, model_ofs[2]);
    end
  endtask

  task automatic test_random();
    bit ok; int nd, ne, p0;
    logic [1:0] sel; logic dir; logic [7:0] cnt;
    for (int n = 0; n < 6; n++) begin
      sel = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      cnt = 8'($urandom_range(0, 5));
      p0 = pulses;
      issue(sel, dir, cnt, ok);
      wait_idle(nd, ne, ok);
      model_ofs[sel] = dir ? model_ofs[sel] + cnt : model_ofs[sel] - cnt;
      checks++;
      if (pulses - p0 != int'(cnt) || nd != 1 || ne != 0 || bad_width != 0) begin
        failures++;
        $display("FAIL rand%0d_cmd pulses=%0d done=%0d err=%0d want %0d 1 0", n, pulses - p0, nd, ne, cnt);
      end
      for (int i = 0; i < 4; i++) begin
        rd_sel = 2'(i); #1;
        checks++;
        if (rd_ofs !== model_ofs[i]) begin
          failures++;
          $display("FAIL rand%0d_ofs[%0d] got=%h want=%h", n, i, rd_ofs, model_ofs[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    bit ok; int k, bad_ready, nd;
    issue(2'b00, 1'b1, 8'd2, ok);
    req_sel = 2'b11; req_dir = 1'b1; req_count = 8'd9; req_valid = 1'b1;
    k = 0; bad_ready = 0; nd = 0;
    while (busy === 1'b1 && k < 2000) begin
      if (req_ready === 1'b1) bad_ready++;
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
      k++;
    end
    req_valid = 1'b0;
    model_ofs[0] = model_ofs[0] + 8'd2;
    checks++;
    if (bad_ready != 0 || nd != 1 || k >= 2000) begin
      failures++;
      $display("FAIL busy_ignore ready_while_busy=%0d done=%0d want 0 1", bad_ready, nd);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (rd_ofs !== model_ofs[i]) begin
        failures++;
        $display("FAIL busy_ofs[%0d] got=%h want=%h", i, rd_ofs, model_ofs[i]);
      end
    end
  endtask

  task automatic test_lock_gate();
    bit ok; int nd, ne, stuck;
    pll_locked = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lock_gate_ready got=%b want=0", req_ready);
    end
    req_sel = 2'b01; req_dir = 1'b1; req_count = 8'd1; req_valid = 1'b1;
    stuck = 0;
    repeat (4) begin @(posedge clk); #1; if (busy !== 1'b0) stuck++; end
    checks++;
    if (stuck != 0) begin
      failures++;
      $display("FAIL lock_gate_held busy_cycles=%0d want=0", stuck);
    end
    pll_locked = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lock_gate_edge1 ready=%b want=0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL lock_gate_edge2 ready=%b want=1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL lock_gate_accept busy=%b want=1", busy);
    end
    wait_idle(nd, ne, ok);
    model_ofs[1] = model_ofs[1] + 8'd1;
    rd_sel = 2'b01; #1;
    checks++;
    if (rd_ofs !== model_ofs[1] || nd != 1 || !ok) begin
      failures++;
      $display("FAIL lock_gate_ofs got=%h done=%0d want=%h 1", rd_ofs, nd, model_ofs[1]);
    end
  endtask

  task automatic test_timeout();
    bit ok; int k, p0;
    p0 = pulses;
    issue(2'b10, 1'b1, 8'd4, ok);
    k = 0;
    while (phasestep !== 1'b0 && k < 100) begin @(posedge clk); #1; k++; end
    pll_locked = 1'b0;
    k = 0;
    while (phasestep !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    k = 0;
    while (err !== 1'b1 && k < 3000) begin @(posedge clk); #1; k++; end
    model_ofs[2] = model_ofs[2] + 8'd1;
    checks++;
    if (k != SETTLE_CYC + LOCK_TO) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=%0d", k, SETTLE_CYC + LOCK_TO);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_return busy=%b err=%b done=%b want 0 0 0", busy, err, done);
    end
    rd_sel = 2'b10; #1;
    checks++;
    if (rd_ofs !== model_ofs[2] || pulses - p0 != 1) begin
      failures++;
      $display("FAIL timeout_ofs got=%h pulses=%0d want=%h 1", rd_ofs, pulses - p0, model_ofs[2]);
    end
    pll_locked = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok; int k, p0;
    issue(2'b11, 1'b0, 8'd3, ok);
    k = 0;
    while (phasestep !== 1'b0 && k < 100) begin @(posedge clk); #1; k++; end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_ofs[i] = 8'd0;
    checks++;
    if (phasestep !== 1'b1 || busy !== 1'b0 || phasesel !== 2'b00 || k >= 100) begin
      failures++;
      $display("FAIL midpulse_reset step=%b busy=%b sel=%b want 1 0 00", phasestep, busy, phasesel);
    end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (rd_ofs !== 8'd0) begin
        failures++;
        $display("FAIL midpulse_ofs[%0d] got=%h want=00", i, rd_ofs);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = pulses;
    k = 0;
    repeat (12) begin @(posedge clk); #1; if (busy !== 1'b0 || phasestep !== 1'b1) k++; end
    checks++;
    if (k != 0 || pulses != p0) begin
      failures++;
      $display("FAIL release_no_pulse active_cycles=%0d pulses=%0d want 0 0", k, pulses - p0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dir_steps();
    test_count_zero();
    test_random();
    test_busy_ignore();
    test_lock_gate();
    test_timeout();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulx3s_pll_phase_ctrl.md
ULX3S_PLL_PHASE_CTRL -- requirements
Module: ulx3s_pll_phase_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, cycles phasesel/phasedir are stable before a step pulse.
REQ-002 SHALL have parameter PULSE_CYC, default 4, width in cycles of the active-low phasestep pulse.
REQ-003 SHALL have parameter SETTLE_CYC, default 16, cycles waited after each pulse before sampling lock.
REQ-004 SHALL have parameter LOCK_TO, default 1024, cycles allowed for pll_locked to reassert before error.
REQ-005 clk  input  1  single clock (PLL output domain); all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  command present; req_ready  output  1  command accepted when both high.
REQ-008 req_sel  input  2  target output: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP.
REQ-009 req_dir  input  1  1 = advance, 0 = delay; req_count  input  8  number of steps.
REQ-010 pll_locked  input  1  PLL LOCK, asynchronous to clk.
REQ-011 phasesel  output  2; phasedir  output  1; phasestep  output  1 (idle 1); phaseloadreg  output  1 (constant 1).
REQ-012 done  output  1  one-cycle pulse on successful completion; err  output  1  one-cycle pulse on lock timeout.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 rd_sel  input  2; rd_ofs  output  8  signed net step offset of output rd_sel, combinational read.

Function
REQ-015 pll_locked SHALL pass a 2-flop synchronizer before any use; lock_s denotes the synchronized value.
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE, SETTLE, WAITLOCK, DONE, ERR.
REQ-017 req_ready SHALL equal (state==IDLE) && lock_s; handshake latches sel, dir, count into internal registers.
REQ-018 Accepted command with count 0 SHALL go IDLE->DONE directly, no pulse issued, offsets unchanged.
REQ-019 Accepted nonzero command SHALL go to SETUP; phasesel/phasedir SHALL update on the acceptance edge and stay constant until return to IDLE.
REQ-020 SETUP SHALL last SETUP_CYC cycles, then PULSE.
REQ-021 PULSE SHALL drive phasestep 0 for exactly PULSE_CYC cycles, then SETTLE; phasestep SHALL be 1 in all other states.
REQ-022 On PULSE exit, offset[sel] SHALL be incremented (dir=1) or decremented (dir=0) mod 256 and remaining count decremented.
REQ-023 SETTLE SHALL last SETTLE_CYC cycles, then WAITLOCK.
REQ-024 WAITLOCK: lock_s=1 with remaining count>0 -> SETUP; lock_s=1 with remaining 0 -> DONE; LOCK_TO cycles without lock_s -> ERR.
REQ-025 DONE and ERR SHALL each last one cycle, pulsing done or err respectively, then return to IDLE.
REQ-026 ERR SHALL abandon remaining steps; offsets keep steps already issued.
REQ-027 Loss of lock_s during SETUP/PULSE/SETTLE SHALL NOT abort the current step; only WAITLOCK evaluates lock.
REQ-028 req_valid while busy SHALL be ignored (ready low); no command queuing.
REQ-029 All timing counters SHALL be sized to the largest parameter and reload on each state entry.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, phasestep 1, phasesel 00, phasedir 0, done/err/busy 0, all offsets 0, synchronizer flops 0.
REQ-031 Reset mid-pulse SHALL return phasestep to 1 immediately; no partial offset update.
REQ-032 Release of rst_n SHALL not by itself issue any pulse.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and the 2-bit output-select encoding constants.
REQ-034 Synchronizer SHALL be sub-module sync2 (2-flop, async active-low reset); rest is one flat module.

Verification
REQ-035 Lock high, cmd sel=01 dir=1 count=3 -> three phasestep low pulses of 4 cycles, each preceded by >=4 stable-sel cycles, spaced >=20 cycles; done once; rd_sel=01 reads +3.
REQ-036 Then sel=01 dir=0 count=5 -> five pulses; rd_ofs(01)=0xFE (-2); other offsets 0.
REQ-037 Count=0 command -> no pulse, done pulse 2 cycles after handshake (IDLE->DONE->IDLE).
REQ-038 Hold pll_locked low after first pulse of count=4 -> err pulse 1024 cycles after WAITLOCK entry, one step recorded, busy falls.
REQ-039 Assert rst_n low during PULSE -> phasestep 1 same edge-independent, state IDLE, offsets 0; req_valid while busy never handshakes.
REQ-040 pll_locked low at idle -> req_ready 0; command held until lock returns, then accepted 2 cycles after lock rises.
